pe_seq_ctrl: RTL

Sequencer for a single MAC processing element (pe: clk, rst, en, input_ifmap, input_filter, output_psum).
- Accepts a dot-product job (vector length), clears the PE accumulator and streams operand pairs into it through a valid/ready input.
- Waits out the PE pipeline latency, then presents the final psum on a valid/ready output.
- Sits between the operand buffers and one PE; later array controllers instantiate one per PE.

---
 rtl/pe_ctrl_pkg.sv | 17 +
 rtl/pe.sv | 27 ++
 rtl/pe_seq_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pe_ctrl_pkg.sv
// Shared types and defaults for the PE sequencer.
// State encoding and parameter defaults live here so controllers and benches agree.
package pe_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 8;
  localparam int PE_LAT_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/pe.sv
// Single MAC processing element: psum accumulates ifmap*filter on each en cycle.
// One register stage, so output_psum reflects an en cycle one clock later.
module pe #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] input_ifmap,
  input  logic [DATA_W-1:0] input_filter,
  output logic [DATA_W-1:0] output_psum
);

  logic [2*DATA_W-1:0] prod;

  assign prod = input_ifmap * input_filter;

  // Sum wraps modulo 2^DATA_W; only the low half of the product matters.
  always_ff @(posedge clk) begin
    if (rst) begin
      output_psum <= '0;
    end else if (en) begin
      output_psum <= output_psum + prod[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequencer feeding one MAC PE: clears it, streams a dot-product job through it,
// waits out the PE latency and hands the final psum out on a valid/ready port.
module pe_seq_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int PE_LAT = PE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_ifmap,
  input  logic [DATA_W-1:0] in_filter,
  output logic              pe_rst,
  output logic              pe_en,
  output logic [DATA_W-1:0] pe_ifmap,
  output logic [DATA_W-1:0] pe_filter,
  input  logic [DATA_W-1:0] pe_psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_psum,
  output state_e            dbg_state
);

  localparam logic [2:0] DRAIN_LAST = 3'(PE_LAT - 1);

  state_e           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] count;
  logic [2:0]       drain_cnt;
  logic             handshake;

  // Both ports are plain valid/ready: a transfer happens on any clock edge where
  // valid and ready are both high; valid never waits on ready, and in_ready /
  // out_valid are registered so they depend only on state.
  assign handshake = in_valid & in_ready;

  assign busy      = (state != ST_IDLE);
  assign pe_rst    = rst | (state == ST_CLEAR);
  assign pe_en     = handshake;
  assign pe_ifmap  = in_ifmap;
  assign pe_filter = in_filter;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len       <= '0;
      count     <= '0;
      drain_cnt <= '0;
      out_psum  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len   <= vec_len;
            count <= '0;
            state <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          drain_cnt <= '0;
          if (len != '0) begin
            state    <= ST_RUN;
            in_ready <= 1'b1;
          end else begin
            state <= ST_DRAIN;
          end
        end

        ST_RUN: begin
          if (handshake) begin
            count <= count + 1'b1;
            if (count == len - 1'b1) begin
              state     <= ST_DRAIN;
              in_ready  <= 1'b0;
              drain_cnt <= '0;
            end
          end
        end

        // The PE output trails the last en cycle by PE_LAT clocks.
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            out_psum  <= pe_psum;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
